// File: rtl/kung_adder.sv
// Brent-Kung parallel-prefix adder with registered sum/cout; latency 1 cycle.
// No backpressure: accepts one operation per cycle, outputs hold when in_valid is low.
module kung_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             out_valid
);

    localparam int LG = $clog2(WIDTH);
    localparam int NS = 2 * LG;

    // Stage 0 is bit level, stages 1..LG the up-sweep, LG+1..NS-1 the down-sweep.
    logic [WIDTH-1:0] gs [NS];
    logic [WIDTH-1:0] ps [NS];
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_next;
    logic             unused_p;

    genvar i, k, m;

    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (i == 0) begin : g_cin
                assign gs[0][i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cin);
            end else begin : g_plain
                assign gs[0][i] = a[i] & b[i];
            end
            assign ps[0][i] = a[i] ^ b[i];
        end

        for (k = 0; k < LG; k++) begin : g_up
            for (i = 0; i < WIDTH; i++) begin : g_node
                if (((i + 1) % (2 ** (k + 1))) == 0) begin : g_op
                    assign gs[k+1][i] = gs[k][i] | (ps[k][i] & gs[k][i - 2 ** k]);
                    assign ps[k+1][i] = ps[k][i] & ps[k][i - 2 ** k];
                end else begin : g_pass
                    assign gs[k+1][i] = gs[k][i];
                    assign ps[k+1][i] = ps[k][i];
                end
            end
        end

        for (m = 0; m < LG - 1; m++) begin : g_down
            localparam int K = LG - 2 - m;
            for (i = 0; i < WIDTH; i++) begin : g_node
                if ((i >= 3 * (2 ** K) - 1) && (((i + 1 - 2 ** K) % (2 ** (K + 1))) == 0)) begin : g_op
                    assign gs[LG+m+1][i] = gs[LG+m][i] | (ps[LG+m][i] & gs[LG+m][i - 2 ** K]);
                    assign ps[LG+m+1][i] = ps[LG+m][i] & ps[LG+m][i - 2 ** K];
                end else begin : g_pass
                    assign gs[LG+m+1][i] = gs[LG+m][i];
                    assign ps[LG+m+1][i] = ps[LG+m][i];
                end
            end
        end
    endgenerate

    // Group propagate of the full span is not needed for the sum.
    assign unused_p = ^ps[NS-1];

    assign c        = {gs[NS-1], cin};
    assign sum_next = ps[0] ^ c[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_next;
                cout <= c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_kung_adder.sv
// Directed and random checks of kung_adder against a behavioural a+b+cin scoreboard.
module tb_kung_adder;

    logic        clk;
    logic        rst;
    logic [15:0] sum;
    logic        cout;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        in_valid;
    logic        out_valid;

    int          n_cmp;
    int          n_err;
    logic [16:0] sb_q [$];
    logic [16:0] last_res;

    kung_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .sum       (sum),
        .cout      (cout),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then check the registered outputs after the rising edge.
    task automatic step(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                        input logic ci, input logic vi);
        logic [16:0] e;
        @(negedge clk);
        a        = ai;
        b        = bi;
        cin      = ci;
        in_valid = vi;
        if (vi) sb_q.push_back({1'b0, ai} + {1'b0, bi} + {16'd0, ci});
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, {31'd0, out_valid}, {31'd0, vi});
        if (vi) begin
            e = sb_q.pop_front();
            chk(tag, {15'd0, cout, sum}, {15'd0, e});
            last_res = e;
        end else begin
            chk({tag, "_hold"}, {15'd0, cout, sum}, {15'd0, last_res});
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        last_res = '0;
        rst      = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        step("idle", 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        step("nocarry", 16'h1234, 16'h4321, 1'b0, 1'b1);
        step("sgn_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        step("sub_5m3", 16'h0005, 16'hFFFC, 1'b1, 1'b1);
        step("sub_3m5", 16'h0003, 16'hFFFA, 1'b1, 1'b1);
        step("hold1", 16'h1111, 16'h2222, 1'b1, 1'b0);
        step("chain_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        step("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        step("alt", 16'hAAAA, 16'h5555, 1'b1, 1'b1);

        // Asynchronous reset between clock edges, then an operand presented during reset.
        #2 rst = 1'b1;
        #1;
        chk("arst_sum", {16'd0, sum}, 32'd0);
        chk("arst_cout", {31'd0, cout}, 32'd0);
        chk("arst_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        a        = 16'h0F0F;
        b        = 16'h0F0F;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rstin_sum", {15'd0, cout, sum}, 32'd0);
        chk("rstin_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        last_res = '0;
        step("post_rst_idle", 16'h1234, 16'h1234, 1'b0, 1'b0);
        step("post_rst_first", 16'h8000, 16'h8000, 1'b0, 1'b1);

        for (int n = 0; n < 10000; n++) begin
            step("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
